// File: rtl/alu_issue_if.sv
// Issue-stage handshake bundle: instruction in, decoded op out, writeback port.
// slave = issue stage view, master = environment driving it.
interface alu_issue_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [1:0]  out_alu_op;
    logic        out_alt;
    logic [1:0]  out_alu2_op;
    logic        out_alt2;
    logic        out_sel;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    modport slave (
        input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_a, out_b, out_alu_op, out_alt,
               out_alu2_op, out_alt2, out_sel, out_rd, illegal
    );

    modport master (
        output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_alu_op, out_alt,
               out_alu2_op, out_alt2, out_sel, out_rd, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI decode and issue with scoreboard stall and WB bypass.
// Latency 1 cycle; one-deep output register, stalls on RAW hazard or held output.
module alu_issue #(
    parameter bit RESET_REGS = 1'b1
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_issue_if.slave io
);
    logic [31:0] rf_q [32];
    logic [31:0] busy_q, busy_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [1:0]  alu_op_q, alu_op_d, alu2_op_q, alu2_op_d;
    logic        alt_q, alt_d, alt2_q, alt2_d, sel_q, sel_d;
    logic [4:0]  rd_q;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val;
    logic        illegal_dec, use_rs1, use_rs2, alt_bit;
    logic        hazard, accept, issue;

    assign opcode = io.in_instr[6:0];
    assign rd     = io.in_instr[11:7];
    assign funct3 = io.in_instr[14:12];
    assign rs1    = io.in_instr[19:15];
    assign rs2    = io.in_instr[24:20];
    assign funct7 = io.in_instr[31:25];

    // Same-cycle writeback wins over the stored value, so the read sees the new data.
    function automatic logic [31:0] rd_port(input logic [4:0] addr);
        if (addr == 5'd0)                         rd_port = 32'd0;
        else if (io.wb_en && io.wb_rd == addr)    rd_port = io.wb_data;
        else                                      rd_port = rf_q[addr];
    endfunction

    function automatic logic src_hazard(input logic [4:0] addr);
        src_hazard = (addr != 5'd0) && busy_q[addr] && !(io.wb_en && io.wb_rd == addr);
    endfunction

    assign rs1_val = rd_port(rs1);
    assign rs2_val = rd_port(rs2);

    always_comb begin
        alu_op_d    = 2'd0;
        alt_d       = 1'b0;
        alu2_op_d   = 2'd0;
        alt2_d      = 1'b0;
        sel_d       = 1'b0;
        illegal_dec = 1'b0;
        use_rs1     = 1'b1;
        use_rs2     = 1'b0;
        alt_bit     = 1'b0;
        out_a_d     = rs1_val;
        out_b_d     = rs2_val;
        case (opcode)
            7'b0110011: begin
                use_rs2 = 1'b1;
                alt_bit = funct7[5];
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    illegal_dec = 1'b1;
            end
            7'b0010011: begin
                out_b_d = {{20{io.in_instr[31]}}, io.in_instr[31:20]};
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    out_b_d = {27'd0, rs2};
                    alt_bit = funct7[5];
                    if (!(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b101)))
                        illegal_dec = 1'b1;
                end
            end
            7'b0110111: begin
                use_rs1 = 1'b0;
                out_a_d = 32'd0;
                out_b_d = {io.in_instr[31:12], 12'd0};
            end
            default: begin
                use_rs1     = 1'b0;
                illegal_dec = 1'b1;
            end
        endcase

        if (opcode == 7'b0110111) begin
            sel_d     = 1'b1;
            alu2_op_d = 2'd3;
        end else begin
            case (funct3)
                3'b000: alt_d = alt_bit;
                3'b001: sel_d = 1'b1;
                3'b010: begin sel_d = 1'b1; alu2_op_d = 2'd1; alt2_d = 1'b1; end
                3'b011: begin sel_d = 1'b1; alu2_op_d = 2'd1; end
                3'b100: alu_op_d = 2'd2;
                3'b101: begin sel_d = 1'b1; alu2_op_d = 2'd2; alt2_d = alt_bit; end
                3'b110: alu_op_d = 2'd3;
                default: alu_op_d = 2'd1;
            endcase
        end
    end

    assign hazard      = (use_rs1 && src_hazard(rs1)) || (use_rs2 && src_hazard(rs2));
    assign io.in_ready = (!out_valid_q || io.out_ready) && (illegal_dec || !hazard);
    assign accept      = io.in_valid && io.in_ready;
    assign issue       = accept && !illegal_dec;
    assign illegal_d   = accept && illegal_dec;
    assign out_valid_d = issue || (out_valid_q && !io.out_ready);

    // Set beats clear when issue and writeback target the same register.
    always_comb begin
        busy_d = busy_q;
        if (io.wb_en) busy_d[io.wb_rd] = 1'b0;
        if (issue && rd != 5'd0) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= 32'd0;
            out_b_q     <= 32'd0;
            alu_op_q    <= 2'd0;
            alt_q       <= 1'b0;
            alu2_op_q   <= 2'd0;
            alt2_q      <= 1'b0;
            sel_q       <= 1'b0;
            rd_q        <= 5'd0;
            illegal_q   <= 1'b0;
            busy_q      <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            if (issue) begin
                out_a_q   <= out_a_d;
                out_b_q   <= out_b_d;
                alu_op_q  <= alu_op_d;
                alt_q     <= alt_d;
                alu2_op_q <= alu2_op_d;
                alt2_q    <= alt2_d;
                sel_q     <= sel_d;
                rd_q      <= rd;
            end
        end
    end

    generate
        if (RESET_REGS) begin : g_rf_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
                end else if (io.wb_en && io.wb_rd != 5'd0) begin
                    rf_q[io.wb_rd] <= io.wb_data;
                end
            end
        end else begin : g_rf_norst
            always_ff @(posedge clk) begin
                if (io.wb_en && io.wb_rd != 5'd0) rf_q[io.wb_rd] <= io.wb_data;
            end
        end
    endgenerate

    assign io.out_valid   = out_valid_q;
    assign io.out_a       = out_a_q;
    assign io.out_b       = out_b_q;
    assign io.out_alu_op  = alu_op_q;
    assign io.out_alt     = alt_q;
    assign io.out_alu2_op = alu2_op_q;
    assign io.out_alt2    = alt2_q;
    assign io.out_sel     = sel_q;
    assign io.out_rd      = rd_q;
    assign io.illegal     = illegal_q;
endmodule
